// File: rtl/pong_pkg.sv
// Shared encodings and default game geometry for the pong paddle, ball and score blocks.
package pong_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StSlow = 2'd1,
        StFast = 2'd2
    } paddle_state_t;

    typedef enum logic [1:0] {
        DirNone = 2'd0,
        DirUp   = 2'd1,
        DirDn   = 2'd2
    } dir_t;

    localparam int unsigned c_DEF_GAME_HEIGHT   = 30;
    localparam int unsigned c_DEF_PADDLE_HEIGHT = 6;
    localparam int unsigned c_DEF_COORD_W       = 6;

    // True when a and b are the two distinct real directions.
    function automatic logic dir_opposite(input dir_t a, input dir_t b);
        return ((a == DirUp) && (b == DirDn)) || ((a == DirDn) && (b == DirUp));
    endfunction

endpackage

// File: rtl/pong_step_timer.sv
// Step-period counter: counts clocks and emits a one-cycle tick on the last count of the
// selected (slow or fast) period. A clear holds the count at zero and suppresses the tick.
module pong_step_timer
    import pong_pkg::*;
#(
    parameter int unsigned c_CNT_W      = 32,
    parameter int unsigned c_SPEED_SLOW = 1250000,
    parameter int unsigned c_SPEED_FAST = 625000
) (
    input  logic i_Clk,
    input  logic i_Rst_n,
    input  logic i_Clear,
    input  logic i_Fast,
    output logic o_Tick
);

    localparam logic [c_CNT_W-1:0] c_SLOW_LAST = c_CNT_W'(c_SPEED_SLOW - 1);
    localparam logic [c_CNT_W-1:0] c_FAST_LAST = c_CNT_W'(c_SPEED_FAST - 1);

    logic [c_CNT_W-1:0] r_Cnt;
    logic [c_CNT_W-1:0] w_Last;

    assign w_Last = i_Fast ? c_FAST_LAST : c_SLOW_LAST;
    assign o_Tick = !i_Clear && (r_Cnt == w_Last);

    // Counter: cleared on request, wraps to zero on the tick, otherwise increments.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_Cnt <= '0;
        end else if (i_Clear || o_Tick) begin
            r_Cnt <= '0;
        end else begin
            r_Cnt <= r_Cnt + c_CNT_W'(1);
        end
    end

endmodule

// File: rtl/pong_paddle_ctrl_gen.sv
// Paddle controller: button or ball-tracking request, slow/fast acceleration FSM, paddle row
// register and a registered draw flag for the divided pixel grid.
module pong_paddle_ctrl_gen
    import pong_pkg::*;
#(
    parameter int unsigned c_PLAYER_PADDLE_X = 0,
    parameter int unsigned c_PADDLE_HEIGHT   = c_DEF_PADDLE_HEIGHT,
    parameter int unsigned c_GAME_HEIGHT     = c_DEF_GAME_HEIGHT,
    parameter int unsigned c_COORD_W         = c_DEF_COORD_W,
    parameter int unsigned c_SPEED_SLOW      = 1250000,
    parameter int unsigned c_SPEED_FAST      = 625000,
    parameter int unsigned c_ACCEL_STEPS     = 4,
    parameter int unsigned c_CNT_W           = 32
) (
    input  logic                 i_Clk,
    input  logic                 i_Rst_n,
    input  logic                 i_Mode_AI,
    input  logic                 i_Paddle_Up,
    input  logic                 i_Paddle_Dn,
    input  logic [c_COORD_W-1:0] i_Ball_Y,
    input  logic [c_COORD_W-1:0] i_Col_Count_Div,
    input  logic [c_COORD_W-1:0] i_Row_Count_Div,
    output logic [c_COORD_W-1:0] o_Paddle_Y,
    output logic                 o_Draw_Paddle,
    output logic                 o_Moving
);

    localparam int unsigned c_EXT_W  = c_COORD_W + 1;
    localparam int unsigned c_STEP_W = $clog2(c_ACCEL_STEPS + 1);
    localparam int unsigned c_Y_MAX  = c_GAME_HEIGHT - c_PADDLE_HEIGHT;

    localparam logic [c_COORD_W-1:0] c_Y_MAX_V = c_COORD_W'(c_Y_MAX);
    localparam logic [c_COORD_W-1:0] c_Y_RST   = c_COORD_W'(c_Y_MAX / 2);
    localparam logic [c_COORD_W-1:0] c_X       = c_COORD_W'(c_PLAYER_PADDLE_X);
    localparam logic [c_EXT_W-1:0]   c_HALF_H  = c_EXT_W'(c_PADDLE_HEIGHT / 2);
    localparam logic [c_EXT_W-1:0]   c_H_EXT   = c_EXT_W'(c_PADDLE_HEIGHT);
    localparam logic [c_STEP_W-1:0]  c_ACCEL_V = c_STEP_W'(c_ACCEL_STEPS);

    if (64'(c_GAME_HEIGHT) > (64'd1 << c_COORD_W)) begin : g_chk_coord
        $error("c_GAME_HEIGHT does not fit in c_COORD_W bits");
    end
    if ((c_PADDLE_HEIGHT == 0) || (c_PADDLE_HEIGHT >= c_GAME_HEIGHT)) begin : g_chk_height
        $error("c_PADDLE_HEIGHT must be between 1 and c_GAME_HEIGHT-1");
    end
    if ((c_SPEED_FAST < 1) || (c_SPEED_FAST > c_SPEED_SLOW)
        || (64'(c_SPEED_SLOW) >= (64'd1 << c_CNT_W))) begin : g_chk_speed
        $error("step periods must satisfy 1 <= fast <= slow < 2**c_CNT_W");
    end
    if (c_ACCEL_STEPS < 1) begin : g_chk_accel
        $error("c_ACCEL_STEPS must be at least 1");
    end

    paddle_state_t        r_State, w_State_Next;
    dir_t                 r_Dir, w_Dir_Next, w_Req;
    logic [c_STEP_W-1:0]  r_Step, w_Step_Next, w_Step_Inc;
    logic [c_COORD_W-1:0] r_Y, w_Y_Next;
    logic                 r_Mode_AI, r_Moving, r_Draw;
    logic                 w_Clear, w_Tick, w_At_Limit, w_Mode_Chg, w_Draw_Next;
    logic [c_EXT_W-1:0]   w_Centre, w_Ball_Ext, w_Row_Ext, w_Y_Ext;

    assign w_Y_Ext    = {1'b0, r_Y};
    assign w_Ball_Ext = {1'b0, i_Ball_Y};
    assign w_Row_Ext  = {1'b0, i_Row_Count_Div};
    assign w_Centre   = w_Y_Ext + c_HALF_H;
    assign w_Mode_Chg = (i_Mode_AI != r_Mode_AI);
    assign w_Step_Inc = r_Step + c_STEP_W'(1);
    assign w_At_Limit = ((r_Dir == DirUp) && (r_Y == '0)) || ((r_Dir == DirDn) && (r_Y == c_Y_MAX_V));

    pong_step_timer #(
        .c_CNT_W      (c_CNT_W),
        .c_SPEED_SLOW (c_SPEED_SLOW),
        .c_SPEED_FAST (c_SPEED_FAST)
    ) u_step_timer (
        .i_Clk   (i_Clk),
        .i_Rst_n (i_Rst_n),
        .i_Clear (w_Clear),
        .i_Fast  (r_State == StFast),
        .o_Tick  (w_Tick)
    );

    // Request decode: buttons in manual mode, ball row versus paddle centre in AI mode.
    always_comb begin
        w_Req = DirNone;
        if (i_Mode_AI) begin
            if (w_Ball_Ext < w_Centre) begin
                w_Req = DirUp;
            end else if (w_Ball_Ext > w_Centre) begin
                w_Req = DirDn;
            end
        end else begin
            if (i_Paddle_Up && !i_Paddle_Dn) begin
                w_Req = DirUp;
            end else if (i_Paddle_Dn && !i_Paddle_Up) begin
                w_Req = DirDn;
            end
        end
    end

    // Next state, direction, step count, paddle row and timer clear.
    always_comb begin
        w_State_Next = r_State;
        w_Dir_Next   = r_Dir;
        w_Step_Next  = r_Step;
        w_Y_Next     = r_Y;
        w_Clear      = 1'b0;
        if (w_Mode_Chg) begin
            w_State_Next = StIdle;
            w_Clear      = 1'b1;
        end else begin
            unique case (r_State)
                StIdle: begin
                    w_Clear = 1'b1;
                    if (w_Req != DirNone) begin
                        w_State_Next = StSlow;
                        w_Dir_Next   = w_Req;
                        w_Step_Next  = '0;
                    end
                end
                StSlow, StFast: begin
                    if (w_Req == DirNone) begin
                        w_State_Next = StIdle;
                        w_Clear      = 1'b1;
                    end else if (dir_opposite(w_Req, r_Dir)) begin
                        // Reversal restarts slow from a fresh period with no move this cycle.
                        w_State_Next = StSlow;
                        w_Dir_Next   = w_Req;
                        w_Step_Next  = '0;
                        w_Clear      = 1'b1;
                    end else if (w_Tick && !w_At_Limit) begin
                        w_Y_Next = (r_Dir == DirUp) ? r_Y - c_COORD_W'(1) : r_Y + c_COORD_W'(1);
                        if (r_State == StSlow) begin
                            w_Step_Next = w_Step_Inc;
                            if (w_Step_Inc == c_ACCEL_V) begin
                                w_State_Next = StFast;
                            end
                        end
                    end
                end
                default: begin
                    w_State_Next = StIdle;
                    w_Clear      = 1'b1;
                end
            endcase
        end
    end

    // Draw compare in one extra bit so Y+H cannot wrap.
    assign w_Draw_Next = (i_Col_Count_Div == c_X) && (w_Row_Ext >= w_Y_Ext)
                         && (w_Row_Ext < (w_Y_Ext + c_H_EXT));

    // State and output registers; everything clears asynchronously.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_State   <= StIdle;
            r_Dir     <= DirNone;
            r_Step    <= '0;
            r_Y       <= c_Y_RST;
            r_Mode_AI <= 1'b0;
            r_Moving  <= 1'b0;
            r_Draw    <= 1'b0;
        end else begin
            r_State   <= w_State_Next;
            r_Dir     <= w_Dir_Next;
            r_Step    <= w_Step_Next;
            r_Y       <= w_Y_Next;
            r_Mode_AI <= i_Mode_AI;
            r_Moving  <= (w_State_Next != StIdle);
            r_Draw    <= w_Draw_Next;
        end
    end

    assign o_Paddle_Y    = r_Y;
    assign o_Draw_Paddle = r_Draw;
    assign o_Moving      = r_Moving;

endmodule
